// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from ID/EX/IMEM and control outputs to IF/ID, PC and ID/EX
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs2, ex_mem_read, branch_taken, imem_ready;
  logic PC_write, register_write, IF_Flush, ID_EX_bubble, fetch_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, branch_taken, imem_ready,
    input PC_write, register_write, IF_Flush, ID_EX_bubble, fetch_timeout, stall_count, flush_count
  );
  modport slave (
    input id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, branch_taken, imem_ready,
    output PC_write, register_write, IF_Flush, ID_EX_bubble, fetch_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and imem wait sequencing for IF/ID and PC
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_MAX = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, FLUSH, IMEM_WAIT} state_t;
  state_t state, state_nxt;
  logic [1:0] flush_left, flush_left_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic fetch_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic load_use, flushing, br, hold, stall;
  logic pc_write, reg_write, if_flush, bubble;
  assign load_use = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                    (bus.ex_rd == bus.id_rs1 || (bus.id_uses_rs2 && bus.ex_rd == bus.id_rs2));
  // state, flush countdown and wait counter; reset returns to RUN immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      flush_left <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      flush_left <= flush_left_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end
  // next state: FLUSH ignores inputs, branch beats stall, imem miss beats stall only once already waiting
  always_comb begin
    state_nxt = flushing ? (flush_left == 2'd1 ? RUN : FLUSH) :
                br ? (FLUSH_CYCLES > 1 ? FLUSH : RUN) :
                hold ? IMEM_WAIT : RUN;
    flush_left_nxt = flushing ? flush_left - 2'd1 : br ? 2'(FLUSH_CYCLES - 1) : flush_left;
    wait_cnt_nxt = !hold ? wait_cnt :
                   state != IMEM_WAIT ? 8'd1 :
                   wait_cnt == 8'(WAIT_MAX) ? wait_cnt : wait_cnt + 8'd1;
  end
  // zero-latency control outputs; reset holds IF/ID and PC frozen with NOPs injected
  always_comb begin
    flushing = state == FLUSH;
    br = !flushing && bus.branch_taken;
    hold = !flushing && !br && !bus.imem_ready && (state == IMEM_WAIT || !load_use);
    stall = !flushing && !br && !hold && load_use;
    pc_write = rst_n && !stall && !hold;
    reg_write = rst_n && !stall;
    if_flush = !rst_n || flushing || br || hold;
    bubble = !rst_n || br || stall;
  end
  // sticky watchdog and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      fetch_timeout <= fetch_timeout || wait_cnt_nxt == 8'(WAIT_MAX);
      stall_count <= stall_count + CNT_W'(stall && !(&stall_count));
      flush_count <= flush_count + CNT_W'(if_flush && !(&flush_count));
    end
  end
  assign bus.PC_write = pc_write;
  assign bus.register_write = reg_write;
  assign bus.IF_Flush = if_flush;
  assign bus.ID_EX_bubble = bubble;
  assign bus.fetch_timeout = fetch_timeout;
  assign bus.stall_count = stall_count;
  assign bus.flush_count = flush_count;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for two parameterisations of pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic rn;
    logic [4:0] rs1, rs2;
    logic u2;
    logic [4:0] rd;
    logic mr, bt, rdy;
  } in_t;
  typedef struct packed {
    logic pc, rw, fl, bub, to;
    logic [15:0] sc, fc;
  } outs_t;
  typedef struct {
    string n;
    logic b;
    outs_t v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  in_t cur;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  pipeline_hazard_ctrl_if #(.CNT_W(4)) ifa ();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) ifb ();
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .WAIT_MAX(4), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .WAIT_MAX(16), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  assign ifa.id_rs1 = cur.rs1;
  assign ifa.id_rs2 = cur.rs2;
  assign ifa.id_uses_rs2 = cur.u2;
  assign ifa.ex_rd = cur.rd;
  assign ifa.ex_mem_read = cur.mr;
  assign ifa.branch_taken = cur.bt;
  assign ifa.imem_ready = cur.rdy;
  assign ifb.id_rs1 = cur.rs1;
  assign ifb.id_rs2 = cur.rs2;
  assign ifb.id_uses_rs2 = cur.u2;
  assign ifb.ex_rd = cur.rd;
  assign ifb.ex_mem_read = cur.mr;
  assign ifb.branch_taken = cur.bt;
  assign ifb.imem_ready = cur.rdy;
  always #5 clk = ~clk;
  function automatic in_t mk(int rs1, int rs2, int u2, int rd, int mr, int bt, int rdy);
    return {1'b1, 5'(rs1), 5'(rs2), 1'(u2), 5'(rd), 1'(mr), 1'(bt), 1'(rdy)};
  endfunction
  function automatic in_t idle();
    return mk(1, 2, 1, 3, 0, 0, 1);
  endfunction
  function automatic in_t rst_row();
    in_t r = idle();
    r.rn = 1'b0;
    return r;
  endfunction
  function automatic in_t lu();
    return mk(5, 2, 1, 5, 1, 0, 1);
  endfunction
  function automatic outs_t ex(logic [3:0] c, logic to, int sc, int fc);
    return {c, to, 16'(sc), 16'(fc)};
  endfunction
  function automatic outs_t obs(logic b);
    return b ? {ifb.PC_write, ifb.register_write, ifb.IF_Flush, ifb.ID_EX_bubble, ifb.fetch_timeout,
                ifb.stall_count, ifb.flush_count}
             : {ifa.PC_write, ifa.register_write, ifa.IF_Flush, ifa.ID_EX_bubble, ifa.fetch_timeout,
                12'd0, ifa.stall_count, 12'd0, ifa.flush_count};
  endfunction
  task automatic apply(in_t s);
    cur = s;
    rst_n = s.rn;
  endtask
  task automatic test_reset();
    in_t s[$];
    outs_t w[$];
    exp_t e;
    outs_t got;
    s = '{rst_row(), idle(), mk(1, 2, 1, 3, 0, 1, 1), idle(), rst_row(), idle(), idle()};
    w = '{ex(4'b0011, 0, 0, 0), ex(4'b1100, 0, 0, 0), ex(4'b1111, 0, 0, 0), ex(4'b1110, 0, 0, 1),
          ex(4'b0011, 0, 0, 0), ex(4'b1100, 0, 0, 0), ex(4'b1100, 0, 0, 0)};
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back('{$sformatf("reset[%0d]", i), 1'b1, w[i]});
      @(negedge clk);
      e = sb.pop_front();
      got = obs(e.b);
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", e.n, got, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_load_use();
    in_t s[$];
    outs_t w[$];
    exp_t e;
    outs_t got;
    s = '{rst_row(), lu(), mk(0, 2, 1, 0, 1, 0, 1), mk(1, 5, 0, 5, 1, 0, 1), mk(1, 5, 1, 5, 1, 0, 1), idle()};
    w = '{ex(4'b0011, 0, 0, 0), ex(4'b0001, 0, 0, 0), ex(4'b1100, 0, 1, 0), ex(4'b1100, 0, 1, 0),
          ex(4'b0001, 0, 1, 0), ex(4'b1100, 0, 2, 0)};
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back('{$sformatf("load_use[%0d]", i), 1'b0, w[i]});
      @(negedge clk);
      e = sb.pop_front();
      got = obs(e.b);
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", e.n, got, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_branch_flush();
    in_t s[$];
    outs_t w[$];
    exp_t e;
    outs_t got;
    s = '{rst_row(), mk(1, 2, 1, 3, 0, 1, 1), mk(1, 2, 1, 3, 0, 1, 1), idle(), idle(),
          mk(1, 2, 1, 3, 0, 1, 0), mk(1, 2, 1, 3, 0, 0, 0), mk(1, 2, 1, 3, 0, 0, 0), idle()};
    w = '{ex(4'b0011, 0, 0, 0), ex(4'b1111, 0, 0, 0), ex(4'b1110, 0, 0, 1), ex(4'b1100, 0, 0, 2),
          ex(4'b1100, 0, 0, 2), ex(4'b1111, 0, 0, 2), ex(4'b1110, 0, 0, 3), ex(4'b0110, 0, 0, 4),
          ex(4'b1100, 0, 0, 5)};
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back('{$sformatf("branch[%0d]", i), 1'b0, w[i]});
      @(negedge clk);
      e = sb.pop_front();
      got = obs(e.b);
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", e.n, got, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_branch_load_use();
    in_t s[$];
    outs_t w[$];
    exp_t e;
    outs_t got;
    s = '{rst_row(), mk(5, 2, 1, 5, 1, 1, 1), lu(), lu(), idle()};
    w = '{ex(4'b0011, 0, 0, 0), ex(4'b1111, 0, 0, 0), ex(4'b1110, 0, 0, 1), ex(4'b0001, 0, 0, 2),
          ex(4'b1100, 0, 1, 2)};
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back('{$sformatf("branch_lu[%0d]", i), 1'b0, w[i]});
      @(negedge clk);
      e = sb.pop_front();
      got = obs(e.b);
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", e.n, got, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_imem_wait();
    in_t s[$];
    outs_t w[$];
    exp_t e;
    outs_t got;
    in_t miss;
    miss = mk(1, 2, 1, 3, 0, 0, 0);
    s = '{rst_row(), miss, miss, miss, idle(), miss, mk(5, 2, 1, 5, 1, 0, 0), miss, miss, lu(), idle(),
          rst_row(), idle()};
    w = '{ex(4'b0011, 0, 0, 0), ex(4'b0110, 0, 0, 0), ex(4'b0110, 0, 0, 1), ex(4'b0110, 0, 0, 2),
          ex(4'b1100, 0, 0, 3), ex(4'b0110, 0, 0, 3), ex(4'b0110, 0, 0, 4), ex(4'b0110, 0, 0, 5),
          ex(4'b0110, 0, 0, 6), ex(4'b0001, 1, 0, 7), ex(4'b1100, 1, 1, 7), ex(4'b0011, 0, 0, 0),
          ex(4'b1100, 0, 0, 0)};
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back('{$sformatf("imem_wait[%0d]", i), 1'b0, w[i]});
      @(negedge clk);
      e = sb.pop_front();
      got = obs(e.b);
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", e.n, got, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_saturation();
    in_t s[$];
    outs_t w[$];
    exp_t e;
    outs_t got;
    s.push_back(rst_row());
    w.push_back(ex(4'b0011, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      s.push_back(lu());
      w.push_back(ex(4'b0001, 0, i < 15 ? i : 15, 0));
      s.push_back(idle());
      w.push_back(ex(4'b1100, 0, i + 1 < 15 ? i + 1 : 15, 0));
    end
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back('{$sformatf("saturate[%0d]", i), 1'b0, w[i]});
      @(negedge clk);
      e = sb.pop_front();
      got = obs(e.b);
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", e.n, got, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    apply(rst_row());
    test_reset();
    test_load_use();
    test_branch_flush();
    test_branch_load_use();
    test_imem_wait();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
